// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker: lock-state enum, LFSR step,
// saturating add and the standard tap masks.
package prbs_pkg;

  localparam int unsigned PRBS_MAX_W = 64;

  // Tap masks: x^k term lives at bit k-1
  localparam logic [31:0] PRBS7  = 32'h0000_0060;
  localparam logic [31:0] PRBS9  = 32'h0000_0110;
  localparam logic [31:0] PRBS11 = 32'h0000_0500;
  localparam logic [31:0] PRBS15 = 32'h0000_6000;
  localparam logic [31:0] PRBS23 = 32'h0042_0000;
  localparam logic [31:0] PRBS31 = 32'h4800_0000;
  localparam logic [31:0] PRBS32 = 32'h8020_0003;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    SEEDING  = 2'd1,
    LOCKED   = 2'd2
  } prbs_state_e;

  function automatic logic [PRBS_MAX_W-1:0] prbs_step(
    input logic [PRBS_MAX_W-1:0] x,
    input logic [PRBS_MAX_W-1:0] poly,
    input int unsigned           iterations,
    input int unsigned           width
  );
    logic [PRBS_MAX_W-1:0] s;
    logic [PRBS_MAX_W-1:0] mask;
    mask = {PRBS_MAX_W{1'b1}} >> (PRBS_MAX_W - width);
    s    = x & mask;
    for (int unsigned i = 0; i < iterations; i++)
      s = {s[PRBS_MAX_W-2:0], ^(s & poly)} & mask;
    return s;
  endfunction

  function automatic logic [PRBS_MAX_W-1:0] sat_add(
    input logic [PRBS_MAX_W-1:0] a,
    input logic [PRBS_MAX_W-1:0] b,
    input int unsigned           width
  );
    logic [PRBS_MAX_W:0] sum;
    logic [PRBS_MAX_W:0] lim;
    lim = {1'b0, {PRBS_MAX_W{1'b1}} >> (PRBS_MAX_W - width)};
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[PRBS_MAX_W-1:0] : sum[PRBS_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/prbs_channel_checker.sv
// One PRBS checker channel: self-seeding lock FSM, free-running reference and
// saturating bit-error / checked-word counters.
//
// state    | meaning
// UNSEEDED | waiting for the first word to seed prev
// SEEDING  | counting consecutive words that follow step(prev)
// LOCKED   | comparing against the free-running reference, counting errors
module prbs_channel_checker
  import prbs_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ITERATIONS   = 32,
  parameter logic [DATA_W-1:0] POLY         = DATA_W'(PRBS7),
  parameter int unsigned       LOCK_COUNT   = 4,
  parameter int unsigned       UNLOCK_COUNT = 4,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              clear_counters,
  output logic              locked,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned PC_W  = $clog2(DATA_W) + 1;
  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W = $clog2(UNLOCK_COUNT + 1);

  prbs_state_e       state;
  prbs_state_e       state_nxt;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] ref_word;
  logic [DATA_W-1:0] diff;
  logic [RUN_W-1:0]  run;
  logic [BAD_W-1:0]  bad;
  logic [PC_W-1:0]   diff_ones;
  logic              seed_match;
  logic              lock_hit;
  logic              unlock_hit;

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] x);
    return DATA_W'(prbs_step(PRBS_MAX_W'(x), PRBS_MAX_W'(POLY), ITERATIONS, DATA_W));
  endfunction

  assign seed_match = (data == step(prev));
  assign lock_hit   = seed_match && (run == RUN_W'(LOCK_COUNT - 1));
  assign diff       = data ^ ref_word;
  assign diff_ones  = PC_W'($countones(diff));
  assign unlock_hit = (diff != '0) && (bad == BAD_W'(UNLOCK_COUNT - 1));

  always_ff @(posedge clk) begin
    if (!aresetn) state <= UNSEEDED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (valid) begin
      case (state)
        UNSEEDED: state_nxt = SEEDING;
        SEEDING:  if (lock_hit)   state_nxt = LOCKED;
        LOCKED:   if (unlock_hit) state_nxt = SEEDING;
        default:  state_nxt = UNSEEDED;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // The reference keeps stepping in LOCKED so a corrupted word cannot poison it
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      prev     <= '1;
      ref_word <= '1;
      run      <= '0;
      bad      <= '0;
    end else if (valid) begin
      case (state)
        UNSEEDED: prev <= data;
        SEEDING: begin
          prev <= data;
          if (lock_hit) begin
            run      <= '0;
            bad      <= '0;
            ref_word <= step(data);
          end else if (seed_match) begin
            run <= run + 1'b1;
          end else begin
            run <= '0;
          end
        end
        LOCKED: begin
          ref_word <= step(ref_word);
          if (diff == '0) begin
            bad <= '0;
          end else if (unlock_hit) begin
            bad  <= '0;
            run  <= '0;
            prev <= data;
          end else begin
            bad <= bad + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn || clear_counters) begin
      bit_err_cnt <= '0;
      word_cnt    <= '0;
    end else if (valid && state == LOCKED) begin
      word_cnt    <= CNT_W'(sat_add(PRBS_MAX_W'(word_cnt), PRBS_MAX_W'(1), CNT_W));
      bit_err_cnt <= CNT_W'(sat_add(PRBS_MAX_W'(bit_err_cnt), PRBS_MAX_W'(diff_ones), CNT_W));
    end
  end

endmodule

// File: rtl/prbs_multi_checker.sv
// N-channel PRBS checker: independent channel checkers sharing one beat valid
// and one counter clear.
module prbs_multi_checker
  import prbs_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ITERATIONS   = 32,
  parameter logic [DATA_W-1:0] POLY         = DATA_W'(PRBS7),
  parameter int unsigned       N_CHANNELS   = 1,
  parameter int unsigned       LOCK_COUNT   = 4,
  parameter int unsigned       UNLOCK_COUNT = 4,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [DATA_W*N_CHANNELS-1:0] S_AXIS_TDATA,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic                         clear_counters,
  output logic [N_CHANNELS-1:0]        locked,
  output logic [CNT_W*N_CHANNELS-1:0]  bit_err_cnt,
  output logic [CNT_W*N_CHANNELS-1:0]  word_cnt
);

  assign S_AXIS_TREADY = 1'b1;

  for (genvar j = 0; j < N_CHANNELS; j++) begin : g_ch
    prbs_channel_checker #(
      .DATA_W       (DATA_W),
      .ITERATIONS   (ITERATIONS),
      .POLY         (POLY),
      .LOCK_COUNT   (LOCK_COUNT),
      .UNLOCK_COUNT (UNLOCK_COUNT),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk            (clk),
      .aresetn        (aresetn),
      .data           (S_AXIS_TDATA[DATA_W*j +: DATA_W]),
      .valid          (S_AXIS_TVALID),
      .clear_counters (clear_counters),
      .locked         (locked[j]),
      .bit_err_cnt    (bit_err_cnt[CNT_W*j +: CNT_W]),
      .word_cnt       (word_cnt[CNT_W*j +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prbs_multi_checker.sv
// Bench for prbs_multi_checker: two DUTs (32-bit and 4-bit counters) share one
// stimulus; a word-level model of the lock/count rules supplies expectations.
module tb_prbs_multi_checker;

  localparam int          NC   = 2;
  localparam int          LK   = 4;
  localparam int          UL   = 4;
  localparam logic [31:0] POLY = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tvalid = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] tdata = '0;
  logic        tready_a, tready_b;
  logic [1:0]  locked_a, locked_b;
  logic [63:0] berr_a, words_a;
  logic [7:0]  berr_b, words_b;

  always #5 clk = ~clk;

  prbs_multi_checker #(.DATA_W(32), .ITERATIONS(32), .POLY(POLY), .N_CHANNELS(NC),
    .LOCK_COUNT(LK), .UNLOCK_COUNT(UL), .CNT_W(32)) dut_a (
    .clk(clk), .aresetn(aresetn), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready_a), .clear_counters(clear), .locked(locked_a),
    .bit_err_cnt(berr_a), .word_cnt(words_a));

  prbs_multi_checker #(.DATA_W(32), .ITERATIONS(32), .POLY(POLY), .N_CHANNELS(NC),
    .LOCK_COUNT(LK), .UNLOCK_COUNT(UL), .CNT_W(4)) dut_b (
    .clk(clk), .aresetn(aresetn), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready_b), .clear_counters(clear), .locked(locked_b),
    .bit_err_cnt(berr_b), .word_cnt(words_b));

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = waiting for seed, 1 = hunting, 2 = locked
  int          m_mode[NC];
  logic [31:0] m_prev[NC], m_ref[NC], gen[NC];
  int          m_run[NC], m_bad[NC];
  longint      m_err[NC], m_words[NC];

  function automatic logic [31:0] nxt(input logic [31:0] x);
    logic [31:0] s = x;
    repeat (32) s = (s << 1) | 32'(^(s & POLY));
    return s;
  endfunction

  function automatic logic [31:0] sat(input longint v, input int w);
    longint lim = (longint'(1) << w) - 1;
    return 32'((v > lim) ? lim : v);
  endfunction

  function automatic logic [1:0] exp_lk();
    return {m_mode[1] == 2, m_mode[0] == 2};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c] = 0; m_prev[c] = '1; m_ref[c] = '1;
      m_run[c] = 0; m_bad[c] = 0; m_err[c] = 0; m_words[c] = 0;
    end
  endtask

  task automatic model_channel(input int c, input logic [31:0] d);
    logic [31:0] diff;
    if (m_mode[c] == 0) begin
      m_prev[c] = d; m_mode[c] = 1;
    end else if (m_mode[c] == 1) begin
      if (d == nxt(m_prev[c])) begin
        m_run[c]++;
        if (m_run[c] == LK) begin
          m_mode[c] = 2; m_ref[c] = nxt(d); m_run[c] = 0; m_bad[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_prev[c] = d;
    end else begin
      diff = d ^ m_ref[c];
      m_ref[c] = nxt(m_ref[c]);
      m_words[c]++;
      m_err[c] += $countones(diff);
      if (diff != 0) begin
        m_bad[c]++;
        if (m_bad[c] == UL) begin
          m_mode[c] = 1; m_prev[c] = d; m_run[c] = 0; m_bad[c] = 0;
        end
      end else begin
        m_bad[c] = 0;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d0, input logic [31:0] d1,
                       input bit clr, input bit rst);
    tvalid = v; tdata = {d1, d0}; clear = clr; aresetn = ~rst;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (v) begin
        model_channel(0, d0);
        model_channel(1, d1);
      end
      if (clr) for (int c = 0; c < NC; c++) begin m_err[c] = 0; m_words[c] = 0; end
    end
    @(negedge clk);
    tvalid = 1'b0; clear = 1'b0; aresetn = 1'b1;
  endtask

  task automatic get_words(output logic [31:0] d0, output logic [31:0] d1);
    d0 = gen[0]; d1 = gen[1];
    gen[0] = nxt(gen[0]); gen[1] = nxt(gen[1]);
  endtask

  task automatic beat_clean();
    logic [31:0] d0, d1;
    get_words(d0, d1);
    drive(1'b1, d0, d1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++; if (locked_a !== 2'b00 || locked_b !== 2'b00) begin errors++;
      $display("FAIL reset_locked: got %b/%b want 00/00", locked_a, locked_b); end
    checks++; if (berr_a !== 64'd0 || words_a !== 64'd0) begin errors++;
      $display("FAIL reset_cnt_a: got err=%h words=%h want 0", berr_a, words_a); end
    checks++; if (berr_b !== 8'd0 || words_b !== 8'd0) begin errors++;
      $display("FAIL reset_cnt_b: got err=%h words=%h want 0", berr_b, words_b); end
    checks++; if (tready_a !== 1'b1 || tready_b !== 1'b1) begin errors++;
      $display("FAIL tready: got %b/%b want 1/1", tready_a, tready_b); end
  endtask

  task automatic test_seed_lock();
    gen[0] = 32'hFFFF_FFFF; gen[1] = 32'hFFFF_FFFF;
    for (int i = 1; i <= 5; i++) begin
      beat_clean();
      if (i == 4) begin
        checks++; if (locked_a !== 2'b00) begin errors++;
          $display("FAIL early_lock: got %b want 00 after beat 4", locked_a); end
      end
    end
    checks++; if (locked_a !== 2'b11 || locked_b !== 2'b11) begin errors++;
      $display("FAIL lock_beat5: got %b/%b want 11/11", locked_a, locked_b); end
    repeat (100) beat_clean();
    checks++; if (words_a !== {32'd100, 32'd100}) begin errors++;
      $display("FAIL words_100: got %h want 100 per channel", words_a); end
    checks++; if (berr_a !== 64'd0) begin errors++;
      $display("FAIL clean_errs: got %h want 0", berr_a); end
    checks++; if (words_b !== {4'(sat(m_words[1], 4)), 4'(sat(m_words[0], 4))}) begin errors++;
      $display("FAIL words_sat4: got %h want ff", words_b); end
  endtask

  task automatic test_single_err();
    logic [31:0] d0, d1;
    get_words(d0, d1);
    drive(1'b1, d0, d1 ^ 32'h0000_0080, 1'b0, 1'b0);
    checks++; if (berr_a[63:32] !== 32'd1 || berr_a[31:0] !== 32'd0) begin errors++;
      $display("FAIL single_bit: got ch1=%0d ch0=%0d want 1/0", berr_a[63:32], berr_a[31:0]); end
    checks++; if (locked_a !== 2'b11) begin errors++;
      $display("FAIL single_lock: got %b want 11", locked_a); end
    beat_clean();
    checks++; if (berr_a[63:32] !== 32'd1 || words_a[63:32] !== sat(m_words[1], 32)) begin errors++;
      $display("FAIL after_single: got err=%0d words=%0d want 1/%0d",
               berr_a[63:32], words_a[63:32], m_words[1]); end
  endtask

  task automatic test_loss_relock();
    logic [31:0] d0, d1, e_before;
    logic [1:0]  lk;
    int n;
    for (int i = 0; i < 4; i++) begin
      get_words(d0, d1);
      e_before = berr_a[31:0];
      drive(1'b1, 32'h0, d1, 1'b0, 1'b0);
      checks++; if (berr_a[31:0] !== e_before + 32'($countones(d0))) begin errors++;
        $display("FAIL loss_errs%0d: got %0d want %0d", i, berr_a[31:0], e_before + 32'($countones(d0))); end
      checks++; if (locked_a !== ((i < 3) ? 2'b11 : 2'b10)) begin errors++;
        $display("FAIL loss_lock%0d: got %b want %b", i, locked_a, (i < 3) ? 2'b11 : 2'b10); end
    end
    n = 0;
    while (locked_a[0] !== 1'b1 && n < 12) begin
      beat_clean();
      n++;
      lk = exp_lk();
      checks++; if (locked_a !== lk) begin errors++;
        $display("FAIL relock_trace%0d: got %b want %b", n, locked_a, lk); end
    end
    checks++; if (n !== 5) begin errors++;
      $display("FAIL relock_beats: got %0d beats want 5", n); end
    checks++; if (words_a[31:0] !== sat(m_words[0], 32)) begin errors++;
      $display("FAIL relock_words: got %0d want %0d", words_a[31:0], m_words[0]); end
  endtask

  task automatic test_gaps();
    logic [31:0] w0, w1, e0, e1;
    int nb = 0;
    w0 = words_a[31:0]; w1 = words_a[63:32]; e0 = berr_a[31:0]; e1 = berr_a[63:32];
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 5)) drive(1'b0, $urandom, $urandom, 1'b0, 1'b0);
      beat_clean();
      nb++;
      checks++; if (locked_a !== 2'b11) begin errors++;
        $display("FAIL gap_lock%0d: got %b want 11", i, locked_a); end
    end
    checks++; if (words_a !== {w1 + 32'(nb), w0 + 32'(nb)}) begin errors++;
      $display("FAIL gap_words: got %h want +%0d per channel", words_a, nb); end
    checks++; if (berr_a !== {e1, e0}) begin errors++;
      $display("FAIL gap_errs: got %h want %h", berr_a, {e1, e0}); end
  endtask

  task automatic test_sat_clear();
    logic [31:0] d0, d1, e1;
    for (int k = 0; k < 3; k++) begin
      e1 = berr_a[63:32];
      get_words(d0, d1);
      drive(1'b1, d0, ~d1, 1'b0, 1'b0);
      checks++; if (berr_b[7:4] !== 4'hF || berr_a[63:32] !== e1 + 32'd32) begin errors++;
        $display("FAIL sat_err%0d: got b=%0d a=%0d want 15/%0d", k, berr_b[7:4], berr_a[63:32], e1 + 32'd32); end
    end
    beat_clean();
    checks++; if (berr_b[7:4] !== 4'hF || words_b !== 8'hFF || locked_b !== 2'b11) begin errors++;
      $display("FAIL sat_hold: got err=%h words=%h lk=%b want f/ff/11", berr_b[7:4], words_b, locked_b); end
    get_words(d0, d1);
    drive(1'b1, d0, ~d1, 1'b1, 1'b0);
    checks++; if (berr_a !== 64'd0 || words_a !== 64'd0 || berr_b !== 8'd0 || words_b !== 8'd0) begin errors++;
      $display("FAIL clear_wins: got %h %h %h %h want 0", berr_a, words_a, berr_b, words_b); end
    for (int k = 0; k < 3; k++) begin
      get_words(d0, d1);
      drive(1'b1, d0, ~d1, 1'b0, 1'b0);
      checks++; if (locked_a !== ((k < 2) ? 2'b11 : 2'b01)) begin errors++;
        $display("FAIL clear_fsm%0d: got %b want %b", k, locked_a, (k < 2) ? 2'b11 : 2'b01); end
    end
    checks++; if (berr_a[63:32] !== 32'd96 || berr_b[7:4] !== 4'hF) begin errors++;
      $display("FAIL post_clear_err: got a=%0d b=%0d want 96/15", berr_a[63:32], berr_b[7:4]); end
    repeat (5) beat_clean();
    checks++; if (locked_a !== 2'b11) begin errors++;
      $display("FAIL sat_relock: got %b want 11", locked_a); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] lk;
    drive(1'b1, $urandom, $urandom, 1'b0, 1'b1);
    checks++; if (locked_a !== 2'b00 || locked_b !== 2'b00) begin errors++;
      $display("FAIL midrst_lock: got %b/%b want 00", locked_a, locked_b); end
    checks++; if (berr_a !== 64'd0 || words_a !== 64'd0 || berr_b !== 8'd0 || words_b !== 8'd0) begin errors++;
      $display("FAIL midrst_cnt: got %h %h %h %h want 0", berr_a, words_a, berr_b, words_b); end
    for (int i = 1; i <= 5; i++) begin
      beat_clean();
      lk = exp_lk();
      checks++; if (locked_a !== ((i < 5) ? 2'b00 : 2'b11) || locked_a !== lk) begin errors++;
        $display("FAIL midrst_relock%0d: got %b want %b", i, locked_a, (i < 5) ? 2'b00 : 2'b11); end
    end
    beat_clean();
    checks++; if (words_a[31:0] !== 32'd1 || berr_a !== 64'd0) begin errors++;
      $display("FAIL midrst_count: got words=%0d err=%h want 1/0", words_a[31:0], berr_a); end
  endtask

  initial begin
    model_reset();
    gen[0] = '1; gen[1] = '1;
    @(negedge clk);
    test_reset();
    test_seed_lock();
    test_single_err();
    test_loss_relock();
    test_gaps();
    test_sat_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
